multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the datapath over multiple cycles (IF/ID/EX/MEM/WB) with one shared ALU and one
//  shared instruction/data memory port, replacing the single-cycle ControlUnit decode.
//  Supports base ops (R, addi, lw, sw, beq) and custom ops (lwi, ss, swap, blt/bge, slli).
//  Owns the memory-wait handshake, memory timeout detection, halt and the retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready per access; exceeding it -> S_ERR
//  CNT_W        32  width of instret counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, synchronous, active-low
//  opcode        in   7      IR[6:0], valid from S_DECODE on
//  zero          in   1      ALU zero flag
//  mem_ready     in   1      memory completes current access this cycle
//  halt_req      in   1      request halt at next instruction boundary
//  ir_write      out  1      load IR from memory read data
//  pc_write      out  1      unconditional PC load
//  pc_write_cond out  1      PC load if zero
//  pc_src        out  1      0 = ALU result, 1 = ALUOut register
//  iord          out  1      0 = PC address, 1 = data address
//  mem_read      out  1      memory read strobe
//  mem_write     out  1      memory write strobe
//  addr_src      out  1      1 = data address from rs1 data (ss)
//  wdata_src     out  1      1 = write data from ALUOut (ss)
//  alu_src_a     out  2      0 = PC, 1 = A (rs1), 2 = B (rs2)
//  alu_src_b     out  2      0 = B, 1 = const 4, 2 = ImmGen
//  aluop         out  2      0 = add, 1 = sub, 2 = funct-decoded
//  reg_write     out  1      regfile write port 1
//  reg_write2    out  1      regfile write port 2 (swap)
//  write_reg_src out  1      1 = write address is rs1 (swap)
//  mem_to_reg    out  1      1 = writeback from MDR
//  busy          out  1      high in every state except S_HALT and S_ERR
//  err           out  1      sticky memory-timeout / illegal-opcode flag
//  instret       out  CNT_W  retired instruction count
// BEHAVIOUR
//  - rst low: next state S_FETCH, wait counter 0, err 0, instret 0; all strobes 0 during the reset cycle.
//  - Outputs decoded from state only (Moore); any unlisted output is 0.
//  - S_FETCH: iord=0, mem_read=1, a=0, b=1, aluop=0. Held until mem_ready; on mem_ready: ir_write=1, pc_write=1, pc_src=0 -> S_DECODE.
//    halt_req=1 on entry cycle (wait counter 0) -> S_HALT, no strobes that cycle.
//  - S_DECODE: a=0, b=2, aluop=0 (branch target into ALUOut). Next state by opcode:
//    0110011 -> S_EXEC_R; 0010011/0010100 -> S_EXEC_I; 0000011/0100011 -> S_ADDR_I; 0000100 -> S_ADDR_RR;
//    0100100 -> S_EXEC_SS; 1100011/1100100 -> S_BRANCH; 0100101 -> S_SWAP; other -> S_ERR.
//  - S_EXEC_R: a=1, b=0, aluop=2 -> S_WB_ALU.
//  - S_EXEC_I: a=1, b=2, aluop=0 (addi), aluop=2 (slli) -> S_WB_ALU.
//  - S_ADDR_I: a=1, b=2, aluop=0 -> S_MEM_RD (lw) / S_MEM_WR (sw).
//  - S_ADDR_RR: a=1, b=0, aluop=0 -> S_MEM_RD.
//  - S_EXEC_SS: a=2, b=2, aluop=0 -> S_MEM_WR.
//  - S_MEM_RD: iord=1, mem_read=1; held until mem_ready -> S_WB_MEM.
//  - S_MEM_WR: iord=1, mem_write=1; addr_src=wdata_src=1 for ss; held until mem_ready -> S_FETCH.
//  - S_WB_ALU: reg_write=1 -> S_FETCH.
//  - S_WB_MEM: reg_write=1, mem_to_reg=1 -> S_FETCH.
//  - S_BRANCH: a=1, b=0, pc_write_cond=1, pc_src=1; aluop=1 (beq), aluop=2 (1100100) -> S_FETCH.
//  - S_SWAP: reg_write=1, reg_write2=1, write_reg_src=1 -> S_FETCH.
//  - S_HALT: no strobes; leaves to S_FETCH the cycle after halt_req is sampled low.
//  - S_ERR: err=1, no strobes; exit only by reset.
//  - Memory wait: counter clears on entry to S_FETCH/S_MEM_RD/S_MEM_WR and increments each cycle without mem_ready.
//    Reaching MEM_TIMEOUT without mem_ready -> S_ERR. mem_ready on the same cycle wins over timeout.
//  - instret increments (wrapping) on every transition into S_FETCH from a final state; not on reset, halt exit or error.
//  - Zero-wait latency: branch/swap 3 cycles; R/I/sw/ss 4 cycles; lw/lwi 5 cycles.
// STRUCTURE
//  - Package mc_pkg: state enum (4 bits), opcode localparams, alu_src_a/alu_src_b/aluop encodings.
//  - Sub-module mc_wait_timer: clear/enable/ready inputs; timeout output.
// TESTING
//  - addi x2,x0,5 with mem_ready tied 1 -> states F,D,EXI,WBA; reg_write in cycle 4 only; instret 0->1.
//  - lw with mem_ready low 3 cycles in S_MEM_RD -> mem_read held 4 cycles; exactly one reg_write with mem_to_reg=1.
//  - ss -> S_EXEC_SS (a=2, b=2), then S_MEM_WR with addr_src=1, wdata_src=1, mem_write=1.
//  - swap -> 3 cycles; reg_write=reg_write2=write_reg_src=1 in S_SWAP; blt with zero=1 -> pc_write_cond=1, pc_src=1.
//  - mem_ready stuck low in S_FETCH -> S_ERR after 15 cycles, err=1 sticky; rst low 1 cycle -> S_FETCH, err=0, instret=0.
//  - halt_req=1 at instruction boundary -> S_HALT, busy=0; halt_req=0 -> S_FETCH next cycle; opcode 7'h7F -> S_ERR.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding, opcodes, mux/ALU selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ADDR_I  = 4'd4,
        S_ADDR_RR = 4'd5,
        S_EXEC_SS = 4'd6,
        S_MEM_RD  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_WB_ALU  = 4'd9,
        S_WB_MEM  = 4'd10,
        S_BRANCH  = 4'd11,
        S_SWAP    = 4'd12,
        S_HALT    = 4'd13,
        S_ERR     = 4'd14
    } state_t;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SLLI = 7'b0010100;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_LWI  = 7'b0000100;
    localparam logic [6:0] OP_SS   = 7'b0100100;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BLT  = 7'b1100100;
    localparam logic [6:0] OP_SWAP = 7'b0100101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC  = 2'd0;
    localparam logic [1:0] SRCA_RS1 = 2'd1;
    localparam logic [1:0] SRCA_RS2 = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting for mem_ready in one memory access; flags timeout on the last allowed cycle.
// Latency: timeout is combinational from the count and ready of the current cycle.
// Backpressure: none; clear has priority over counting, ready on the same cycle suppresses timeout.
//  clk, rst       : clock, synchronous active-low reset
//  clear          : restart count (controller is changing state)
//  enable         : controller sits in a memory-wait state
//  ready          : memory completes this cycle
//  at_start       : count is zero (first cycle of an access)
//  timeout        : this is the MEM_TIMEOUT-th cycle without ready
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic at_start,
    output logic timeout
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !ready) begin
            count <= count + W'(1);
        end
    end

    assign at_start = (count == '0);
    // Count holds the number of wait cycles already spent, so this cycle is the
    // MEM_TIMEOUT-th one when count has reached MEM_TIMEOUT-1.
    assign timeout  = enable && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a multi-cycle datapath (fetch/decode/execute/memory/writeback) with one ALU and one memory port.
// Latency: branch/swap 3 cycles, R/I/sw/ss 4, lw/lwi 5, plus memory wait cycles.
// Backpressure: stalls in fetch/memory states until mem_ready; MEM_TIMEOUT wait cycles without it -> error state.
//  inputs : clk, rst (sync, active-low), opcode, zero, mem_ready, halt_req
//  outputs: datapath strobes and mux selects, busy, err (sticky), instret (retired count)
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_src,
    output logic             wdata_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             reg_write,
    output logic             reg_write2,
    output logic             write_reg_src,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    state_t state, state_next;
    logic   err_q;
    logic   wait_state, wait_start, wait_timeout, retire;

    // The zero flag is qualified by pc_write_cond inside the datapath.
    logic   unused_zero;
    assign  unused_zero = zero;

    assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    // Any state change restarts the counter, so it is zero on entry to each access.
    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_next != state),
        .enable   (wait_state),
        .ready    (mem_ready),
        .at_start (wait_start),
        .timeout  (wait_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_next == S_ERR) begin
            err_q <= 1'b1;
        end
    end

    // An instruction retires when a terminal state hands back to fetch.
    assign retire = (state_next == S_FETCH) &&
                    ((state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                     (state == S_SWAP)   || (state == S_MEM_WR));

    always_ff @(posedge clk) begin
        if (!rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign err = err_q;

    always_comb begin
        state_next    = state;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        addr_src      = 1'b0;
        wdata_src     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        aluop         = ALU_ADD;
        reg_write     = 1'b0;
        reg_write2    = 1'b0;
        write_reg_src = 1'b0;
        mem_to_reg    = 1'b0;
        busy          = 1'b1;

        case (state)
            S_FETCH: begin
                // Halt is only honoured on the first fetch cycle, i.e. at an
                // instruction boundary before any memory request is issued.
                if (halt_req && wait_start) begin
                    state_next = S_HALT;
                end else begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end else if (wait_timeout) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_R:            state_next = S_EXEC_R;
                    OP_ADDI, OP_SLLI: state_next = S_EXEC_I;
                    OP_LW, OP_SW:    state_next = S_ADDR_I;
                    OP_LWI:          state_next = S_ADDR_RR;
                    OP_SS:           state_next = S_EXEC_SS;
                    OP_BEQ, OP_BLT:  state_next = S_BRANCH;
                    OP_SWAP:         state_next = S_SWAP;
                    default:         state_next = S_ERR;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = SRCA_RS1;
                aluop      = ALU_FUNCT;
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                aluop      = (opcode == OP_SLLI) ? ALU_FUNCT : ALU_ADD;
                state_next = S_WB_ALU;
            end
            S_ADDR_I: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_ADDR_RR: begin
                alu_src_a  = SRCA_RS1;
                state_next = S_MEM_RD;
            end
            S_EXEC_SS: begin
                // ss stores rs2+imm at address rs1: the sum lands in ALUOut as write data.
                alu_src_a  = SRCA_RS2;
                alu_src_b  = SRCB_IMM;
                state_next = S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end else if (wait_timeout) begin
                    state_next = S_ERR;
                end
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                addr_src  = (opcode == OP_SS);
                wdata_src = (opcode == OP_SS);
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (wait_timeout) begin
                    state_next = S_ERR;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                aluop         = (opcode == OP_BLT) ? ALU_FUNCT : ALU_SUB;
                state_next    = S_FETCH;
            end
            S_SWAP: begin
                reg_write     = 1'b1;
                reg_write2    = 1'b1;
                write_reg_src = 1'b1;
                state_next    = S_FETCH;
            end
            S_HALT: begin
                busy = 1'b0;
                if (!halt_req) begin
                    state_next = S_FETCH;
                end
            end
            S_ERR: begin
                busy = 1'b0;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_ERR;
            end
        endcase

        // Keep every strobe quiet while reset is asserted.
        if (!rst) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            addr_src      = 1'b0;
            wdata_src     = 1'b0;
            alu_src_a     = SRCA_PC;
            alu_src_b     = SRCB_RS2;
            aluop         = ALU_ADD;
            reg_write     = 1'b0;
            reg_write2    = 1'b0;
            write_reg_src = 1'b0;
            mem_to_reg    = 1'b0;
            busy          = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction sequences plus hand-written corner cases.
// Each cycle the expected control word and retired count are queued, then popped and compared at the falling edge.
module tb_multicycle_ctrl;

    typedef enum int {
        P_R,    // reset asserted
        P_F,    // fetch, memory ready
        P_FW,   // fetch, memory not ready
        P_FH,   // fetch entry cycle with halt request
        P_D, P_EXR, P_EXI, P_ADI, P_ADRR, P_SS,
        P_MR, P_MRW, P_MW, P_MWW,
        P_WBA, P_WBM, P_BR, P_SW, P_H, P_E
    } phase_t;

    typedef struct packed {
        logic       ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, addr_src, wdata_src;
        logic [1:0] a, b, aluop;
        logic       reg_write, reg_write2, write_reg_src, mem_to_reg, busy, err;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic [31:0] instret;
        logic        chk_instret;
        logic        chk_err;
    } exp_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       z;
        int         n;
        phase_t     ph [5];
    } instr_t;

    localparam logic [6:0] O_R = 7'b0110011, O_ADDI = 7'b0010011, O_SLLI = 7'b0010100,
                           O_LW = 7'b0000011, O_SW = 7'b0100011, O_LWI = 7'b0000100,
                           O_SS = 7'b0100100, O_BEQ = 7'b1100011, O_BLT = 7'b1100100,
                           O_SWAP = 7'b0100101, O_BAD = 7'h7F;

    logic        clk, rst, zero, mem_ready, halt_req;
    logic [6:0]  opcode;
    logic        ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, addr_src, wdata_src;
    logic [1:0]  alu_src_a, alu_src_b, aluop;
    logic        reg_write, reg_write2, write_reg_src, mem_to_reg, busy, err;
    logic [31:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .halt_req(halt_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src), .wdata_src(wdata_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .reg_write(reg_write),
        .reg_write2(reg_write2), .write_reg_src(write_reg_src), .mem_to_reg(mem_to_reg),
        .busy(busy), .err(err), .instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [6:0]  cur_op = 7'd0;
    logic        cur_zero = 1'b0;
    logic [31:0] exp_instret = 32'd0;
    exp_t        sb [$];
    instr_t      tbl [10];

    // Control word expected in each phase, written from the behavioural description.
    function automatic ctl_t exp_ctl(input phase_t ph, input logic [6:0] op);
        ctl_t c;
        c = '0;
        c.busy = !(ph inside {P_R, P_H, P_E});
        case (ph)
            P_F:    begin c.mem_read = 1; c.b = 2'd1; c.ir_write = 1; c.pc_write = 1; end
            P_FW:   begin c.mem_read = 1; c.b = 2'd1; end
            P_D:    c.b = 2'd2;
            P_EXR:  begin c.a = 2'd1; c.aluop = 2'd2; end
            P_EXI:  begin c.a = 2'd1; c.b = 2'd2; c.aluop = (op == O_SLLI) ? 2'd2 : 2'd0; end
            P_ADI:  begin c.a = 2'd1; c.b = 2'd2; end
            P_ADRR: c.a = 2'd1;
            P_SS:   begin c.a = 2'd2; c.b = 2'd2; end
            P_MR, P_MRW: begin c.iord = 1; c.mem_read = 1; end
            P_MW, P_MWW: begin
                c.iord = 1; c.mem_write = 1;
                c.addr_src = (op == O_SS); c.wdata_src = (op == O_SS);
            end
            P_WBA:  c.reg_write = 1;
            P_WBM:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            P_BR:   begin c.a = 2'd1; c.pc_write_cond = 1; c.pc_src = 1; c.aluop = (op == O_BLT) ? 2'd2 : 2'd1; end
            P_SW:   begin c.reg_write = 1; c.reg_write2 = 1; c.write_reg_src = 1; end
            P_E:    c.err = 1;
            default: ;
        endcase
        return c;
    endfunction

    // One clock cycle: drive inputs, queue expectation, compare at the falling edge.
    task automatic step(input phase_t ph, input logic hr);
        exp_t e, got;
        ctl_t act, mask;
        rst       = (ph != P_R);
        mem_ready = !(ph inside {P_FW, P_MRW, P_MWW});
        halt_req  = hr;
        opcode    = cur_op;
        zero      = cur_zero;
        e.ctl         = exp_ctl(ph, cur_op);
        e.instret     = exp_instret;
        e.chk_instret = (ph != P_R);
        e.chk_err     = (ph != P_R);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        act = '{ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, addr_src, wdata_src,
                alu_src_a, alu_src_b, aluop, reg_write, reg_write2, write_reg_src, mem_to_reg, busy, err};
        mask = '1;
        // err is a register; while reset is held it still shows the pre-reset value.
        if (!got.chk_err) mask.err = 1'b0;
        n_cmp++;
        if ((act & mask) !== (got.ctl & mask)) begin
            n_fail++;
            $display("FAIL ctl phase=%s op=%b t=%0t: got %h want %h", ph.name(), cur_op, $time,
                     act & mask, got.ctl & mask);
        end
        if (got.chk_instret) begin
            n_cmp++;
            if (instret !== got.instret) begin
                n_fail++;
                $display("FAIL instret phase=%s t=%0t: got %0d want %0d", ph.name(), $time, instret, got.instret);
            end
        end
        if (ph == P_R) exp_instret = 32'd0;
        else if (ph inside {P_WBA, P_WBM, P_BR, P_SW, P_MW}) exp_instret = exp_instret + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [6:0] op, input logic z, input phase_t ph [$]);
        cur_op = op;
        cur_zero = z;
        foreach (ph[i]) step(ph[i], 1'b0);
    endtask

    initial begin
        tbl[0] = '{"addi", O_ADDI, 1'b0, 4, '{P_F, P_D, P_EXI, P_WBA, P_F}};
        tbl[1] = '{"slli", O_SLLI, 1'b0, 4, '{P_F, P_D, P_EXI, P_WBA, P_F}};
        tbl[2] = '{"rtype", O_R, 1'b0, 4, '{P_F, P_D, P_EXR, P_WBA, P_F}};
        tbl[3] = '{"lw", O_LW, 1'b0, 5, '{P_F, P_D, P_ADI, P_MR, P_WBM}};
        tbl[4] = '{"sw", O_SW, 1'b0, 4, '{P_F, P_D, P_ADI, P_MW, P_F}};
        tbl[5] = '{"lwi", O_LWI, 1'b0, 5, '{P_F, P_D, P_ADRR, P_MR, P_WBM}};
        tbl[6] = '{"ss", O_SS, 1'b0, 4, '{P_F, P_D, P_SS, P_MW, P_F}};
        tbl[7] = '{"beq", O_BEQ, 1'b0, 3, '{P_F, P_D, P_BR, P_F, P_F}};
        tbl[8] = '{"blt", O_BLT, 1'b1, 3, '{P_F, P_D, P_BR, P_F, P_F}};
        tbl[9] = '{"swap", O_SWAP, 1'b0, 3, '{P_F, P_D, P_SW, P_F, P_F}};

        rst = 1'b0; mem_ready = 1'b1; halt_req = 1'b0; opcode = 7'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(P_R, 1'b0);

        // Table-driven: every opcode class with zero-wait memory.
        for (int i = 0; i < 10; i++) begin
            cur_op = tbl[i].op;
            cur_zero = tbl[i].z;
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].ph[j], 1'b0);
        end

        // lw with three wait cycles in the read state.
        run_seq(O_LW, 1'b0, '{P_F, P_D, P_ADI, P_MRW, P_MRW, P_MRW, P_MR, P_WBM});
        // ss with one write wait cycle.
        run_seq(O_SS, 1'b0, '{P_F, P_D, P_SS, P_MWW, P_MW});
        // mem_ready arriving on the last allowed wait cycle beats the timeout.
        run_seq(O_ADDI, 1'b0, '{P_FW, P_FW, P_FW, P_FW, P_FW, P_FW, P_FW, P_FW, P_FW, P_FW,
                                P_FW, P_FW, P_FW, P_FW, P_F, P_D, P_EXI, P_WBA});

        // Halt at an instruction boundary, then resume; halt exit does not retire.
        step(P_FH, 1'b1);
        step(P_H, 1'b1);
        step(P_H, 1'b0);
        run_seq(O_ADDI, 1'b0, '{P_F, P_D, P_EXI, P_WBA});

        // Illegal opcode -> sticky error, cleared by a single reset cycle.
        run_seq(O_BAD, 1'b0, '{P_F, P_D, P_E, P_E, P_E});
        step(P_R, 1'b0);
        run_seq(O_SWAP, 1'b0, '{P_F, P_D, P_SW});

        // Fetch timeout: 15 cycles without mem_ready, then error stays with mem_ready high.
        cur_op = O_ADDI;
        for (int k = 0; k < 15; k++) step(P_FW, 1'b0);
        step(P_E, 1'b0);
        step(P_E, 1'b0);
        step(P_R, 1'b0);

        // Read timeout in the data access.
        run_seq(O_LW, 1'b0, '{P_F, P_D, P_ADI});
        for (int k = 0; k < 15; k++) step(P_MRW, 1'b0);
        step(P_E, 1'b0);
        step(P_R, 1'b0);
        run_seq(O_ADDI, 1'b0, '{P_F, P_D, P_EXI, P_WBA, P_F});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
